// File: rtl/bla_pkg.sv
// rtl/bla_pkg.sv - shared parameters, stage count helper and stage record for the pipelined subtractor
package bla_pkg;

    localparam int BLA_WIDTH = 16;
    localparam int BLA_SLICE = 4;

    // Number of pipeline stages needed to resolve w bits, s bits per stage
    function automatic int stages(input int w, input int s);
        return w / s;
    endfunction

    // Contents of one pipeline stage at the default width
    typedef struct packed {
        logic                 valid;
        logic [BLA_WIDTH-1:0] diff;
        logic                 borrow;
        logic [BLA_WIDTH-1:0] a_rem;
        logic [BLA_WIDTH-1:0] b_rem;
        logic                 sa;
        logic                 sb;
    } stage_t;

endpackage

// File: rtl/bla_pipe_sub_if.sv
// rtl/bla_pipe_sub_if.sv - operand/result stream bundle for the pipelined subtractor
interface bla_pipe_sub_if
    import bla_pkg::*;
#(
    parameter int WIDTH = BLA_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    // The subtractor itself
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );

    // Producer/consumer side
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

endinterface

// File: rtl/bla_slice.sv
// rtl/bla_slice.sv - combinational borrow-lookahead subtract slice
module bla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;

    // Borrow generate when a=0,b=1; borrow propagates when a==b
    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Each borrow is a flat sum of products of g/p terms and bin, not a ripple chain
    always_comb begin
        logic acc;
        logic term;
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        c[0] = bin;
        for (int i = 0; i < SLICE; i++) begin
            acc = bin;
            for (int j = 0; j <= i; j++) begin
                acc = acc & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            c[i+1] = acc;
        end
    end

    assign d    = a ^ b ^ c[SLICE-1:0];
    assign bout = c[SLICE];

endmodule

// File: rtl/bla_pipe_sub.sv
// rtl/bla_pipe_sub.sv - pipelined a-b-bin subtractor, one borrow-lookahead slice per stage
module bla_pipe_sub
    import bla_pkg::*;
#(
    parameter int WIDTH = BLA_WIDTH,
    parameter int SLICE = BLA_SLICE
) (
    input  logic          clk,
    input  logic          rst,
    bla_pipe_sub_if.slave bus
);

    localparam int STAGES = stages(WIDTH, SLICE);

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("bla_pipe_sub: WIDTH must be a multiple of SLICE");
    end

    // Index k describes the beat feeding slice k: 0 is the input port, k>0 is stage k
    logic [STAGES:0]  src_v;
    logic [STAGES:0]  src_c;
    logic [STAGES:0]  src_sa;
    logic [STAGES:0]  src_sb;
    logic [WIDTH-1:0] src_d [0:STAGES];
    logic [WIDTH-1:0] src_a [0:STAGES-1];
    logic [WIDTH-1:0] src_b [0:STAGES-1];
    logic [STAGES+1:1] rdy;

    assign src_v[0]  = bus.in_valid;
    assign src_c[0]  = bus.bin;
    assign src_sa[0] = bus.a[WIDTH-1];
    assign src_sb[0] = bus.b[WIDTH-1];
    assign src_d[0]  = '0;
    assign src_a[0]  = bus.a;
    assign src_b[0]  = bus.b;

    assign rdy[STAGES+1] = bus.out_ready;
    assign bus.in_ready  = rdy[1];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [SLICE-1:0] d_s;
        logic             c_s;
        logic             v_r;
        logic             c_r;
        logic             sa_r;
        logic             sb_r;
        logic [WIDTH-1:0] d_r;

        bla_slice #(.SLICE(SLICE)) u_slice (
            .a    (src_a[k][k*SLICE +: SLICE]),
            .b    (src_b[k][k*SLICE +: SLICE]),
            .bin  (src_c[k]),
            .d    (d_s),
            .bout (c_s)
        );

        // A stage may take a new beat if it is empty or its occupant moves on this edge
        assign rdy[k+1] = !v_r || rdy[k+2];

        // Stage k+1: accumulate the low result bits and the borrow into the next slice
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r  <= 1'b0;
                d_r  <= '0;
                c_r  <= 1'b0;
                sa_r <= 1'b0;
                sb_r <= 1'b0;
            end else if (rdy[k+1]) begin
                v_r <= src_v[k];
                if (src_v[k]) begin
                    d_r  <= src_d[k] | (WIDTH'(d_s) << (k * SLICE));
                    c_r  <= c_s;
                    sa_r <= src_sa[k];
                    sb_r <= src_sb[k];
                end
            end
        end

        assign src_v[k+1]  = v_r;
        assign src_d[k+1]  = d_r;
        assign src_c[k+1]  = c_r;
        assign src_sa[k+1] = sa_r;
        assign src_sb[k+1] = sb_r;

        // Operands are only carried while some slice still needs them
        if (k + 1 < STAGES) begin : g_rem
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            // Carry the operands alongside the beat for the slices still to come
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (rdy[k+1] && src_v[k]) begin
                    a_r <= src_a[k];
                    b_r <= src_b[k];
                end
            end

            assign src_a[k+1] = a_r;
            assign src_b[k+1] = b_r;
        end
    end

    assign bus.out_valid = src_v[STAGES];
    assign bus.diff      = src_d[STAGES];
    assign bus.bout      = src_c[STAGES];
    assign bus.ovf       = (src_sa[STAGES] != src_sb[STAGES]) &&
                           (src_d[STAGES][WIDTH-1] != src_sa[STAGES]);

endmodule
